// File: rtl/mc_core.sv
// mc_core: multi-cycle core for an ARM data-processing and B/BL subset.
// Each instruction walks FETCH -> DECODE -> EXECUTE. Anything outside the
// subset parks the core in HALT until reset.
// Optional feature: define MC_CORE_COND_EN to evaluate the IR[31:28]
// condition field against NZCV. Without it, every instruction runs as AL.
module mc_core #(
    parameter int          ADDR_W        = 18,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          LITTLE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       dbg_pc,
    output logic [3:0]        dbg_flags
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, ir_r, op_a_r, op_b_r;
    logic        sh_c_r;
    logic [3:0]  nzcv_r;              // {N, Z, C, V}
    logic [31:0] regs_r [0:14];       // R15 is pc_r
    logic        imem_req_r, retire_r, halted_r;

    // Operand fetch and shifter, evaluated while in DECODE
    logic [31:0] rn_val_s, rm_val_s, op2_s, imm_v_s, ror_v_s;
    logic [32:0] lsl_t_s, lsr_t_s, asr_t_s;
    logic [4:0]  rot_s, sh_amt_s;
    logic        sh_c_s;

    // Execute-stage results
    logic        is_dp_s, is_br_s, unsup_s, pass_s, arith_s, test_op_s;
    logic        add_ci_s, v_s, rd_we_s, flags_we_s;
    logic [31:0] add_x_s, add_y_s, res_s, pc_next_s, rd_val_s, br_off_s;
    logic [32:0] sum_s;
    logic [3:0]  nzcv_next_s, rd_idx_s;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

`ifdef MC_CORE_COND_EN
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic ok;
        case (cond)
            4'h0:    ok = f[2];
            4'h1:    ok = !f[2];
            4'h2:    ok = f[1];
            4'h3:    ok = !f[1];
            4'h4:    ok = f[3];
            4'h5:    ok = !f[3];
            4'h6:    ok = f[0];
            4'h7:    ok = !f[0];
            4'h8:    ok = f[1] && !f[2];
            4'h9:    ok = !f[1] || f[2];
            4'hA:    ok = (f[3] == f[0]);
            4'hB:    ok = (f[3] != f[0]);
            4'hC:    ok = !f[2] && (f[3] == f[0]);
            4'hD:    ok = f[2] || (f[3] != f[0]);
            4'hE:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
`else
    // Condition field is deliberately ignored in this build.
    logic unused_cond_s;
    assign unused_cond_s = ^ir_r[31:28];
`endif

    // Sequencer: IDLE -> FETCH -> (wait for imem_valid) -> DECODE -> EXECUTE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = FETCH;
            FETCH:   state_s = imem_valid ? DECODE : FETCH;
            DECODE:  state_s = EXECUTE;
            EXECUTE: state_s = unsup_s ? HALT : FETCH;
            HALT:    state_s = HALT;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Register-file reads (R15 reads as instruction address + 8) and operand2 shifter
    always_comb begin
        rn_val_s = pc_r + 32'd8;
        rm_val_s = pc_r + 32'd8;
        for (int i = 0; i < 15; i++) begin
            rn_val_s = (ir_r[19:16] == i[3:0]) ? regs_r[i] : rn_val_s;
            rm_val_s = (ir_r[3:0]   == i[3:0]) ? regs_r[i] : rm_val_s;
        end
        rot_s    = {ir_r[11:8], 1'b0};
        imm_v_s  = ({24'd0, ir_r[7:0]} >> rot_s) |
                   ({24'd0, ir_r[7:0]} << (6'd32 - {1'b0, rot_s}));
        sh_amt_s = ir_r[11:7];
        lsl_t_s  = {1'b0, rm_val_s} << sh_amt_s;
        lsr_t_s  = {rm_val_s, 1'b0} >> sh_amt_s;
        asr_t_s  = $signed({rm_val_s, 1'b0}) >>> sh_amt_s;
        ror_v_s  = (rm_val_s >> sh_amt_s) | (rm_val_s << (6'd32 - {1'b0, sh_amt_s}));
        op2_s    = rm_val_s;
        sh_c_s   = nzcv_r[1];
        if (ir_r[25]) begin
            op2_s  = imm_v_s;
            sh_c_s = (ir_r[11:8] != 4'd0) ? imm_v_s[31] : nzcv_r[1];
        end else begin
            // A zero shift amount encodes LSL#0, LSR#32, ASR#32 and RRX respectively
            case (ir_r[6:5])
                2'b00: begin
                    op2_s  = (sh_amt_s == 5'd0) ? rm_val_s  : lsl_t_s[31:0];
                    sh_c_s = (sh_amt_s == 5'd0) ? nzcv_r[1] : lsl_t_s[32];
                end
                2'b01: begin
                    op2_s  = (sh_amt_s == 5'd0) ? 32'd0        : lsr_t_s[32:1];
                    sh_c_s = (sh_amt_s == 5'd0) ? rm_val_s[31] : lsr_t_s[0];
                end
                2'b10: begin
                    op2_s  = (sh_amt_s == 5'd0) ? {32{rm_val_s[31]}} : asr_t_s[32:1];
                    sh_c_s = (sh_amt_s == 5'd0) ? rm_val_s[31]       : asr_t_s[0];
                end
                default: begin
                    op2_s  = (sh_amt_s == 5'd0) ? {nzcv_r[1], rm_val_s[31:1]} : ror_v_s;
                    sh_c_s = (sh_amt_s == 5'd0) ? rm_val_s[0]                 : ror_v_s[31];
                end
            endcase
        end
    end

    // Execute: classify, run the ALU and decide register/flag/PC effects
    always_comb begin
        is_dp_s = (ir_r[27:26] == 2'b00) && (ir_r[25] || !ir_r[4]);
        is_br_s = (ir_r[27:25] == 3'b101);
`ifdef MC_CORE_COND_EN
        unsup_s = !(is_dp_s || is_br_s) || (ir_r[31:28] == 4'hF);
        pass_s  = cond_pass(ir_r[31:28], nzcv_r);
`else
        unsup_s = !(is_dp_s || is_br_s);
        pass_s  = 1'b1;
`endif
        arith_s  = 1'b0;
        add_x_s  = op_a_r;
        add_y_s  = op_b_r;
        add_ci_s = 1'b0;
        // Subtractions are folded into x + ~y + carry-in
        case (ir_r[24:21])
            4'h2, 4'hA: begin arith_s = 1'b1; add_y_s = ~op_b_r; add_ci_s = 1'b1; end
            4'h3:       begin arith_s = 1'b1; add_x_s = op_b_r; add_y_s = ~op_a_r; add_ci_s = 1'b1; end
            4'h4, 4'hB: begin arith_s = 1'b1; end
            4'h5:       begin arith_s = 1'b1; add_ci_s = nzcv_r[1]; end
            4'h6:       begin arith_s = 1'b1; add_y_s = ~op_b_r; add_ci_s = nzcv_r[1]; end
            4'h7:       begin arith_s = 1'b1; add_x_s = op_b_r; add_y_s = ~op_a_r; add_ci_s = nzcv_r[1]; end
            default:    begin arith_s = 1'b0; end
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {32'd0, add_ci_s};
        v_s   = (add_x_s[31] == add_y_s[31]) && (sum_s[31] != add_x_s[31]);
        case (ir_r[24:21])
            4'h0, 4'h8: res_s = op_a_r & op_b_r;
            4'h1, 4'h9: res_s = op_a_r ^ op_b_r;
            4'hC:       res_s = op_a_r | op_b_r;
            4'hD:       res_s = op_b_r;
            4'hE:       res_s = op_a_r & ~op_b_r;
            4'hF:       res_s = ~op_b_r;
            default:    res_s = sum_s[31:0];
        endcase
        test_op_s   = (ir_r[24:23] == 2'b10);
        nzcv_next_s = {res_s[31], (res_s == 32'd0),
                       arith_s ? sum_s[32] : sh_c_r,
                       arith_s ? v_s : nzcv_r[0]};
        br_off_s    = {{6{ir_r[23]}}, ir_r[23:0], 2'b00};

        pc_next_s  = pc_r + 32'd4;
        rd_we_s    = 1'b0;
        rd_idx_s   = ir_r[15:12];
        rd_val_s   = res_s;
        flags_we_s = 1'b0;
        if (pass_s && is_br_s) begin
            pc_next_s = pc_r + 32'd8 + br_off_s;
            rd_we_s   = ir_r[24];
            rd_idx_s  = 4'd14;
            rd_val_s  = pc_r + 32'd4;
        end else if (pass_s && is_dp_s) begin
            if (test_op_s) begin
                flags_we_s = 1'b1;
            end else if (ir_r[15:12] == 4'hF) begin
                pc_next_s = res_s & ~32'd3;
            end else begin
                rd_we_s    = 1'b1;
                flags_we_s = ir_r[20];
            end
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // Architectural state: IR capture, operand latch, PC/register/flag commit
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pc_r   <= RESET_PC;
            ir_r   <= 32'd0;
            nzcv_r <= 4'd0;
            op_a_r <= 32'd0;
            op_b_r <= 32'd0;
            sh_c_r <= 1'b0;
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            if (state_r == FETCH && imem_valid) begin
                ir_r <= (LITTLE_ENDIAN != 0) ? byte_swap(imem_rdata) : imem_rdata;
            end
            if (state_r == DECODE) begin
                op_a_r <= rn_val_s;
                op_b_r <= op2_s;
                sh_c_r <= sh_c_s;
            end
            if (state_r == EXECUTE && !unsup_s) begin
                pc_r <= pc_next_s;
                if (flags_we_s) begin
                    nzcv_r <= nzcv_next_s;
                end
                for (int i = 0; i < 15; i++) begin
                    if (rd_we_s && (rd_idx_s == i[3:0])) begin
                        regs_r[i] <= rd_val_s;
                    end
                end
            end
        end
    end

    // Registered status outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            imem_req_r <= 1'b0;
            retire_r   <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            imem_req_r <= (state_s == FETCH);
            retire_r   <= (state_r == EXECUTE) && (state_s == FETCH);
            halted_r   <= (state_s == HALT);
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r[ADDR_W+1:2];
    assign retire    = retire_r;
    assign halted    = halted_r;
    assign dbg_pc    = pc_r;
    assign dbg_flags = nzcv_r;

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed-vector bench for mc_core. The instruction memory is a
// synchronous SRAM: it sees imem_req at a clock edge and answers one cycle
// later (zero wait), plus mem_wait extra cycles. Words are stored as
// little-endian bytes, so the bus carries byte-swapped instructions.
module tb_mc_core;

    logic        clk, n_reset, imem_req, imem_valid, retire, halted;
    logic [17:0] imem_addr;
    logic [31:0] imem_rdata, dbg_pc;
    logic [3:0]  dbg_flags;

    int checks_n   = 0;
    int failures_n = 0;
    int mem_wait   = 0;
    int fetch_age  = 0;
    int ncyc;
    logic [31:0] mem [0:127];

`ifdef MC_CORE_COND_EN
    localparam logic [31:0] R4_EXP = 32'd0;   // MOVEQ skipped because Z=0
`else
    localparam logic [31:0] R4_EXP = 32'd5;   // condition ignored, runs as AL
`endif

    // Program at 0x00..0x34: instruction, destination checked, value, NZCV after
    logic [31:0] prog_v [0:13] = '{
        32'hE3A000FF, 32'hE2901001, 32'hE3B02102, 32'hE0533003,
        32'hE3530001, 32'hE1B05022, 32'hE1B06042, 32'hE1B07060,
        32'hE28F8000, 32'hE0929002, 32'hE2A0C000, 32'hE180A200,
        32'hE3F0B000, 32'hE291F003};
    int          chk_rd [0:13] = '{0, 1, 2, 3, 3, 5, 6, 7, 8, 9, 12, 10, 11, 1};
    logic [31:0] chk_val [0:13] = '{
        32'h000000FF, 32'h00000100, 32'h80000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h8000007F,
        32'h00000028, 32'h00000000, 32'h00000100, 32'h00000FFF,
        32'hFFFFFFFF, 32'h00000100};
    logic [3:0]  chk_nzcv [0:13] = '{
        4'b0000, 4'b0000, 4'b1010, 4'b0110, 4'b1000, 4'b0110, 4'b1010,
        4'b1010, 4'b1010, 4'b0111, 4'b0111, 4'b0111, 4'b1011, 4'b1011};

    mc_core dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .retire     (retire),
        .halted     (halted),
        .dbg_pc     (dbg_pc),
        .dbg_flags  (dbg_flags)
    );

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            failures_n++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_retire(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!retire && !halted && n < limit);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory responder
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (imem_req && n_reset) begin
                if (fetch_age == mem_wait + 1) begin
                    imem_valid = 1'b1;
                    imem_rdata = bswap(mem[imem_addr[6:0]]);
                    fetch_age  = 0;
                end else begin
                    fetch_age++;
                end
            end else begin
                fetch_age = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        for (int i = 0; i < 14; i++) mem[i] = prog_v[i];
        mem[64] = 32'hEBFFFFFE;                 // BL to itself at 0x100

        n_reset = 1'b0;
        repeat (3) step();
        check_eq("rst_req",    {31'd0, imem_req}, 32'd0);
        check_eq("rst_retire", {31'd0, retire},   32'd0);
        check_eq("rst_halted", {31'd0, halted},   32'd0);
        check_eq("rst_pc",     dbg_pc,            32'd0);
        check_eq("rst_flags",  {28'd0, dbg_flags}, 32'd0);
        n_reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            wait_retire(40, ncyc);
            check_eq($sformatf("i%0d_retire", i), {31'd0, retire}, 32'd1);
            if (i > 0) check_eq($sformatf("i%0d_cycles", i), ncyc, 32'd4);
            check_eq($sformatf("i%0d_reg", i), dut.regs_r[chk_rd[i]], chk_val[i]);
            check_eq($sformatf("i%0d_flags", i), {28'd0, dbg_flags}, {28'd0, chk_nzcv[i]});
            check_eq($sformatf("i%0d_pc", i), dbg_pc,
                     (i == 13) ? 32'h100 : 32'((i + 1) * 4));
        end

        // BL with three memory wait cycles
        mem_wait = 3;
        wait_retire(40, ncyc);
        check_eq("bl_retire", {31'd0, retire}, 32'd1);
        check_eq("bl_cycles", ncyc, 32'd7);
        check_eq("bl_pc",     dbg_pc, 32'h100);
        check_eq("bl_r14",    dut.regs_r[14], 32'h104);
        check_eq("bl_flags",  {28'd0, dbg_flags}, 32'hB);

        // Reset in the middle of a long fetch wait
        mem_wait = 20;
        repeat (3) step();
        check_eq("wait_req", {31'd0, imem_req}, 32'd1);
        n_reset = 1'b0;
        step();
        check_eq("mrst_req",    {31'd0, imem_req}, 32'd0);
        check_eq("mrst_pc",     dbg_pc, 32'd0);
        check_eq("mrst_halted", {31'd0, halted}, 32'd0);
        check_eq("mrst_r1",     dut.regs_r[1], 32'd0);
        check_eq("mrst_flags",  {28'd0, dbg_flags}, 32'd0);

        // Condition test then an unsupported encoding
        mem[0] = 32'hE3B00001;                  // MOVS R0,#1   -> Z=0
        mem[1] = 32'h03A04005;                  // MOVEQ R4,#5
        mem[2] = 32'hE7F000F0;                  // undefined
        mem_wait = 0;
        step();
        n_reset = 1'b1;
        wait_retire(40, ncyc);
        check_eq("movs_r0", dut.regs_r[0], 32'd1);
        wait_retire(40, ncyc);
        check_eq("moveq_retire", {31'd0, retire}, 32'd1);
        check_eq("moveq_r4",     dut.regs_r[4], R4_EXP);
        check_eq("moveq_pc",     dbg_pc, 32'h8);
        wait_retire(40, ncyc);
        check_eq("und_halted", {31'd0, halted},   32'd1);
        check_eq("und_retire", {31'd0, retire},   32'd0);
        check_eq("und_pc",     dbg_pc,            32'h8);
        repeat (5) step();
        check_eq("halt_hold", {31'd0, halted},    32'd1);
        check_eq("halt_req",  {31'd0, imem_req},  32'd0);
        check_eq("halt_r0",   dut.regs_r[0],      32'd1);
        check_eq("halt_flags", {28'd0, dbg_flags}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter ADDR_W, default 18, width of the imem_addr word address.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-003 Parameter LITTLE_ENDIAN, default 1; when 1, imem_rdata is byte-swapped into IR; when 0, it is used as-is.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 n_reset  in  1  reset, synchronous and active-low.
REQ-006 imem_req  out  1  fetch request.
REQ-007 imem_addr  out  ADDR_W  word address, equal to PC[ADDR_W+1:2].
REQ-008 imem_rdata  in  32  instruction word, qualified by imem_valid.
REQ-009 imem_valid  in  1  instruction word present this cycle.
REQ-010 retire  out  1  one-cycle pulse per completed instruction.
REQ-011 halted  out  1  core stopped on an unsupported instruction.
REQ-012 dbg_pc  out  32  current PC.
REQ-013 dbg_flags  out  4  CPSR NZCV.

Function
REQ-014 The core SHALL use states IDLE, FETCH, DECODE, EXECUTE, HALT with these transitions:
- IDLE->FETCH after one cycle.
- FETCH->DECODE on the cycle imem_valid=1.
- DECODE->EXECUTE always.
- EXECUTE->FETCH, or EXECUTE->HALT for an unsupported instruction.
- HALT is left only by reset.
REQ-015 imem_req SHALL be 1 exactly while in FETCH, with imem_addr stable until imem_valid; IR is captured on the imem_valid cycle.
REQ-016 A fetch with zero memory wait SHALL give 4 cycles per instruction from FETCH entry to retire; each wait cycle adds exactly 1.
REQ-017 Data processing (IR[27:26]=00, IR[7:4] not 1xx1) SHALL execute all 16 opcodes, AND through MVN, on 32-bit operands.
REQ-018 Immediate operand2 SHALL be imm8 rotated right by 2*rotate_imm; shifter carry is bit31 of the result when rotate_imm!=0, else C.
REQ-019 Register operand2 SHALL support immediate shifts LSL/LSR/ASR/ROR with ARM #0 encodings: LSR#0=LSR#32, ASR#0=ASR#32, ROR#0=RRX.
REQ-020 Register-specified shift (IR[4]=1) SHALL be unsupported.
REQ-021 When S=1, the core SHALL update N and Z; C SHALL come from the adder for arithmetic ops and from the shifter otherwise; V SHALL update for arithmetic ops only.
REQ-022 TST, TEQ, CMP and CMN SHALL write no register and SHALL always update flags.
REQ-023 Reads of R15 as an operand SHALL return the instruction address+8.
REQ-024 A write to Rd=15 SHALL load PC with result&~3 and skip the +4 increment; flags SHALL NOT update.
REQ-025 B/BL (IR[27:25]=101) SHALL set PC = addr+8+(sign-extended imm24<<2); BL SHALL also write R14 = addr+4.
REQ-026 PC arithmetic SHALL wrap modulo 2^32.
REQ-027 All other encodings SHALL be unsupported: halted=1 from the EXECUTE edge onward, no retire pulse, no register or flag change.
REQ-028 retire SHALL pulse on the EXECUTE->FETCH edge; dbg_pc SHALL show the next PC in the same cycle.

Reset
REQ-029 While n_reset=0 at a rising edge, the core SHALL set state=IDLE, PC=RESET_PC, R0-R14=0, NZCV=0, IR=0, imem_req=0, retire=0, halted=0.
REQ-030 Reset during a FETCH wait SHALL drop imem_req on that same edge.
REQ-031 imem_valid arriving while n_reset=0 SHALL be ignored.

Configuration
REQ-032 Macro MC_CORE_COND_EN: when defined, IR[31:28] SHALL be evaluated against NZCV (EQ..AL).
REQ-033 A failed condition SHALL retire with no register, flag or branch effect; PC advances by 4.
REQ-034 cond=1111 SHALL be unsupported.
REQ-035 Without MC_CORE_COND_EN, every instruction SHALL be treated as AL, including cond=1111.

Verification
REQ-036 Zero-wait memory, program MOV R0,#0xFF; ADDS R1,R0,#1 -> R1=0x100, NZCV=0000, retire every 4 cycles.
REQ-037 MOVS R2,#0x80000000 (imm 0x02, rot 1) -> R2=0x80000000, N=1, C=1.
REQ-038 SUBS R3,R3,R3 from reset -> R3=0, Z=1, C=1; then CMP R3,#1 -> N=1, C=0, R3 unchanged.
REQ-039 BL at 0x100 with imm24=0xFFFFFE -> PC=0x100, R14=0x104; imem_valid delayed 3 cycles -> instruction takes 7 cycles.
REQ-040 With MC_CORE_COND_EN, Z=0 and MOVEQ R4,#5 -> R4 unchanged, retire pulses; encoding 0xE7F000F0 -> halted=1, imem_req=0 thereafter.
REQ-041 Reset asserted mid-FETCH wait -> next cycle imem_req=0, dbg_pc=RESET_PC, halted=0.
